// File: rtl/riscv_pkg.sv
// Shared core-wide constants and the fetch FSM state type.
package riscv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetched {pc, instr} pairs with synchronous flush.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [XLEN-1:0]        push_pc_i,
  input  logic [ILEN-1:0]        push_instr_i,
  output logic                   valid_o,
  output logic [XLEN-1:0]        head_pc_o,
  output logic [ILEN-1:0]        head_instr_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q;
  logic            push_ok, pop_ok;
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [ILEN-1:0] instr_mem_q [DEPTH];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop_i && (cnt_q != '0);
  assign push_ok = push_i && ((cnt_q != FULL) || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) begin
      pc_mem_q[wr_q]    <= push_pc_i;
      instr_mem_q[wr_q] <= push_instr_i;
    end
  end

  assign valid_o      = (cnt_q != '0);
  assign head_pc_o    = pc_mem_q[rd_q];
  assign head_instr_o = instr_mem_q[rd_q];
  assign count_o      = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request FSM and fetch PC feeding a small queue toward decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam logic [$clog2(DEPTH):0] Q_FULL = ($clog2(DEPTH)+1)'(DEPTH);

  fetch_state_e           state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        redirect_tgt;
  logic                   push, pop;
  logic                   q_valid;
  logic [XLEN-1:0]        q_pc;
  logic [ILEN-1:0]        q_instr;
  logic [$clog2(DEPTH):0] q_count;

  assign redirect_tgt = redirect_pc & ~64'h3;

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = (q_count < Q_FULL) && !redirect;
        if (imem_req && !imem_ack) state_d = WAIT;
      end
      // The outstanding request stays asserted even under redirect; its data is dropped later.
      WAIT: begin
        imem_req = 1'b1;
        if (imem_ack)      state_d = FETCH;
        else if (redirect) state_d = DISCARD;
      end
      DISCARD: begin
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (rst) imem_req = 1'b0;
  end

  assign push = imem_req && imem_ack && !redirect;
  assign pop  = q_valid && !stall && !redirect;

  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = redirect_tgt;
    else if (push) pc_d = pc_q + 64'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect),
    .push_i       (push),
    .pop_i        (pop),
    .push_pc_i    (pc_q),
    .push_instr_i (imem_rdata),
    .valid_o      (q_valid),
    .head_pc_o    (q_pc),
    .head_instr_o (q_instr),
    .count_o      (q_count)
  );

  assign imem_addr = pc_q;
  assign id_valid  = q_valid;
  assign id_instr  = q_valid ? q_instr : NOP_INSTR;
  assign id_pc     = q_valid ? q_pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: queue-based reference model, randomized memory latency and control.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;

  fetch_unit #(
    .RESET_PC(RST_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Stimulus knobs
  logic        drv_rst = 1'b1, drv_stall = 1'b0, drv_redirect = 1'b0;
  logic [63:0] drv_rpc = '0;
  int          mem_mode = 0;     // <0: random latency 0..3, else fixed latency
  bit          mem_keep = 1'b0;  // keep an in-flight response alive across reset
  bit          mem_busy = 1'b0;
  int          mem_left = 0;

  // Reference model: fetched entries awaiting decode, fetch pointer, in-flight flags
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        mq[$];
  logic [63:0] m_pc = RST_PC;
  bit          m_busy = 1'b0;    // request issued, answer still owed to us
  bit          m_orphan = 1'b0;  // request issued, answer must be thrown away

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int   d;
    logic e_req;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    @(negedge clk);
    rst         = drv_rst;
    stall       = drv_stall;
    redirect    = drv_redirect;
    redirect_pc = drv_rpc;
    #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (mem_busy) begin
      if (rst && !mem_keep) mem_busy = 1'b0;
      else begin
        mem_left--;
        if (mem_left == 0) begin
          imem_ack = 1'b1;
          mem_busy = 1'b0;
        end
      end
    end else if (imem_req) begin
      d = (mem_mode < 0) ? int'($urandom_range(0, 3)) : mem_mode;
      if (d == 0) imem_ack = 1'b1;
      else begin
        mem_busy = 1'b1;
        mem_left = d;
      end
    end
    #1;
    if (rst) begin
      mq.delete();
      m_pc     = RST_PC;
      m_busy   = 1'b0;
      m_orphan = 1'b0;
    end
    e_req   = !rst && (m_busy || (!m_orphan && mq.size() < DEPTH && !redirect));
    e_instr = (mq.size() != 0) ? mq[0].instr : NOP;
    e_pc    = (mq.size() != 0) ? mq[0].pc : 64'h0;
    chk("model_req",   imem_req,  e_req);
    chk("model_addr",  imem_addr, m_pc);
    chk("model_valid", id_valid,  mq.size() != 0);
    chk("model_instr", id_instr,  e_instr);
    chk("model_pc",    id_pc,     e_pc);
    if (!rst) begin
      if (redirect) begin
        mq.delete();
        m_orphan = (m_busy || m_orphan) && !imem_ack;
        m_busy   = 1'b0;
        m_pc     = {redirect_pc[63:2], 2'b00};
      end else begin
        if (mq.size() != 0 && !stall) void'(mq.pop_front());
        if (m_orphan) begin
          if (imem_ack) m_orphan = 1'b0;
        end else if (e_req && imem_ack) begin
          mq.push_back('{pc: m_pc, instr: imem_rdata});
          m_pc   = m_pc + 64'd4;
          m_busy = 1'b0;
        end else if (e_req) begin
          m_busy = 1'b1;
        end
      end
    end
  endtask

  logic [31:0] w1008, w100c;

  initial begin
    // Reset values
    drv_rst = 1'b1; mem_mode = 0;
    step(); step();
    chk("rst_req",   imem_req,  0);
    chk("rst_addr",  imem_addr, 64'h1000);
    chk("rst_valid", id_valid,  0);
    chk("rst_instr", id_instr,  NOP);
    chk("rst_pc",    id_pc,     0);

    // Back-to-back zero-latency fetch
    drv_rst = 1'b0;
    step();
    chk("seq_req0",  imem_req,  1);
    chk("seq_addr0", imem_addr, 64'h1000);
    step();
    chk("seq_addr1", imem_addr, 64'h1004);
    chk("seq_pc1",   id_pc,     64'h1000);
    step();
    chk("seq_addr2", imem_addr, 64'h1008);
    chk("seq_pc2",   id_pc,     64'h1004);
    w1008 = imem_rdata;

    // Stall five cycles: head frozen, queue fills, requests stop
    drv_stall = 1'b1;
    step();
    w100c = imem_rdata;
    chk("stall_pc0", id_pc, 64'h1008);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_instr", id_instr, w1008);
      chk("stall_pc",    id_pc,    64'h1008);
    end
    chk("stall_req_off", imem_req, 0);
    drv_stall = 1'b0;
    step();
    chk("rel_pc0",  id_pc,    64'h1008);
    step();
    chk("rel_pc1",  id_pc,    64'h100c);
    chk("rel_ins1", id_instr, w100c);
    chk("rel_addr", imem_addr, 64'h1010);
    step();
    chk("rel_pc2",  id_pc,    64'h1010);

    // Redirect while a slow request is outstanding
    drv_redirect = 1'b1; drv_rpc = 64'h2000;
    step();
    drv_redirect = 1'b0; mem_mode = 3;
    step();
    chk("wait_addr", imem_addr, 64'h2000);
    chk("wait_req",  imem_req,  1);
    drv_redirect = 1'b1; drv_rpc = 64'h3002;
    step();
    chk("wait_hold", imem_req, 1);
    drv_redirect = 1'b0;
    step();
    chk("disc_req",   imem_req,  0);
    chk("disc_addr",  imem_addr, 64'h3000);
    chk("disc_valid", id_valid,  0);
    step();
    chk("disc_req2",   imem_req, 0);
    chk("disc_valid2", id_valid, 0);
    mem_mode = 0;
    step();
    chk("refetch_addr",  imem_addr, 64'h3000);
    chk("refetch_valid", id_valid,  0);
    mem_mode = 1;
    step();
    chk("refetch_pc", id_pc, 64'h3000);

    // Redirect coinciding with ack under stall
    drv_stall = 1'b1; drv_redirect = 1'b1; drv_rpc = 64'h4000;
    step();
    drv_redirect = 1'b0; mem_mode = 0;
    step();
    chk("rdack_valid", id_valid,  0);
    chk("rdack_instr", id_instr,  NOP);
    chk("rdack_addr",  imem_addr, 64'h4000);
    chk("rdack_req",   imem_req,  1);
    drv_stall = 1'b0;

    // Fetch PC wrap at the top of the address space
    drv_redirect = 1'b1; drv_rpc = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    drv_redirect = 1'b0;
    step();
    chk("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("wrap_addr1", imem_addr, 64'h0);
    chk("wrap_pc",    id_pc,     64'hFFFF_FFFF_FFFF_FFFC);

    // Reset during an outstanding request, stray ack during reset
    mem_mode = 2;
    step();
    chk("rw_req",  imem_req,  1);
    chk("rw_addr", imem_addr, 64'h4);
    mem_keep = 1'b1; drv_rst = 1'b1;
    step();
    chk("rw_rst_req",   imem_req,  0);
    chk("rw_rst_addr",  imem_addr, 64'h1000);
    chk("rw_rst_valid", id_valid,  0);
    chk("rw_rst_instr", id_instr,  NOP);
    step();
    chk("stray_valid", id_valid, 0);
    chk("stray_req",   imem_req, 0);
    mem_keep = 1'b0; drv_rst = 1'b0; mem_mode = 1;
    step();
    chk("post_rst_req",   imem_req,  1);
    chk("post_rst_addr",  imem_addr, 64'h1000);
    chk("post_rst_valid", id_valid,  0);
    step();
    chk("post_rst_valid2", id_valid, 0);
    step();
    chk("post_rst_pc", id_pc, 64'h1000);

    // Randomized traffic
    mem_mode = -1;
    for (int n = 0; n < 3000; n++) begin
      drv_rst      = ($urandom_range(0, 199) == 0);
      drv_stall    = ($urandom_range(0, 99) < 30);
      drv_redirect = ($urandom_range(0, 99) < 8);
      drv_rpc      = {$urandom, $urandom};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, first instruction address after reset.
REQ-002 Parameter DEPTH, default 2, fetch queue entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  64  byte address of requested instruction, word-aligned.
REQ-007 imem_ack  input  1  memory response valid; imem_rdata valid in same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 stall  input  1  hazard-unit hold; decode must not consume this cycle.
REQ-010 redirect  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  input  64  new fetch target; bits [1:0] ignored, treated as 00.
REQ-012 id_valid  output  1  id_instr/id_pc hold a valid instruction for decode.
REQ-013 id_instr  output  32  instruction to decode; 32'h00000013 (NOP) when id_valid=0.
REQ-014 id_pc  output  64  address of id_instr; 0 when id_valid=0.

Function
REQ-015 FSM states: FETCH (may issue), WAIT (request outstanding), DISCARD (outstanding response to be dropped).
REQ-016 FETCH->WAIT when imem_req asserted and imem_ack=0; FETCH stays FETCH when imem_ack=1 in the request cycle.
REQ-017 WAIT->FETCH on imem_ack=1; WAIT->DISCARD on redirect=1 with imem_ack=0.
REQ-018 DISCARD->FETCH on imem_ack=1; imem_rdata in that cycle is dropped.
REQ-019 imem_req asserted in FETCH only when queue occupancy < DEPTH and redirect=0; held high with imem_addr stable until imem_ack.
REQ-020 imem_addr equals fetch PC; fetch PC advances by 4 (64-bit wrap) on each accepted ack.
REQ-021 Accepted ack pushes {fetch PC, imem_rdata} into queue; output valid the cycle after ack (one-cycle latency).
REQ-022 Queue head drives id_valid/id_instr/id_pc directly; pop when id_valid=1 and stall=0.
REQ-023 Push and pop in same cycle at full queue permitted; occupancy unchanged.
REQ-024 stall=1: queue head and outputs held unchanged; fetching continues until queue full.
REQ-025 redirect=1: queue flushed, fetch PC <= {redirect_pc[63:2],2'b00}, id_valid=0 next cycle; redirect overrides stall and any same-cycle push/pop.
REQ-026 redirect with same-cycle imem_ack: response dropped, state FETCH, new request issued next cycle.
REQ-027 Pending request never re-issued or abandoned while imem_req high; DISCARD asserts imem_req=0.

Reset
REQ-028 While rst=1: state FETCH, fetch PC=RESET_PC, queue empty, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=32'h00000013, id_pc=0.
REQ-029 First imem_req asserted in the first rising edge cycle after rst deasserts.
REQ-030 rst mid-transaction aborts it; a late imem_ack after reset with no request outstanding is ignored.

Structure
REQ-031 Shared package riscv_pkg holds XLEN=64, ILEN=32, NOP_INSTR=32'h00000013, fetch FSM state enum.
REQ-032 Queue is sub-module fetch_queue (DEPTH-entry FIFO, flush input, count output); FSM and PC in fetch_unit.

Verification
REQ-033 Reset, RESET_PC=0x1000, ack same cycle as req -> imem_addr 0x1000,0x1004,0x1008 on consecutive cycles; id_pc follows one cycle behind each ack.
REQ-034 stall held 5 cycles, ack always 1 -> id_instr constant, exactly DEPTH entries queued, imem_req drops to 0; release -> in-order 0x1000.. sequence, no loss or duplication.
REQ-035 Request to 0x2000, ack delayed 3 cycles, redirect to 0x3002 in cycle 1 -> data at ack dropped, next imem_addr 0x3000, id_valid=0 until its ack.
REQ-036 redirect and imem_ack same cycle with stall=1 -> queue empty next cycle, id_instr=0x00000013, next request to redirect target.
REQ-037 rst asserted while WAIT -> outputs return to reset values immediately; stray ack next cycle produces no id_valid.
REQ-038 Fetch PC 0xFFFFFFFFFFFFFFFC acked -> next imem_addr 0x0.
